ex_div_unit: RTL and testbench
==============================

EX_DIV_UNIT -- requirements
Module: ex_div_unit

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning datapath width (RV64M).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have port div_en_i, input, 1, divide request from the EX pipeline register; sampled only in IDLE.
REQ-005 SHALL have port div_sel_i, input, 3, op select: 000 div, 001 divu, 010 rem, 011 remu, 100 divw, 101 divuw, 110 remw, 111 remuw.
REQ-006 SHALL have ports src1_i / src2_i, input, XLEN each, dividend / divisor.
REQ-007 SHALL have port flush_i, input, 1, pipeline flush; aborts any operation.
REQ-008 SHALL have port div_busy_o, output, 1, stall request; drives the EX register stall_n low.
REQ-009 SHALL have port div_valid_o, output, 1, one-cycle result strobe.
REQ-010 SHALL have port div_result_o, output, XLEN, quotient or remainder per div_sel_i.

Function
REQ-011 SHALL implement FSM states IDLE, CALC, DONE.
REQ-012 IDLE: div_en_i=1 and flush_i=0 latches operands and div_sel_i; special case (REQ-017/018) -> DONE, else -> CALC with iteration counter N (64 for ops 0xx, 32 for ops 1xx).
REQ-013 CALC: one restoring-division step per cycle (shift remainder left 1, subtract |divisor|, set quotient bit if non-negative); counter decrements; counter reaching 0 -> DONE.
REQ-014 DONE: div_valid_o=1 for exactly one cycle with final div_result_o; -> IDLE unconditionally next edge.
REQ-015 div_busy_o SHALL be combinational: 1 in CALC, and 1 in IDLE when div_en_i=1 and flush_i=0; 0 in DONE and otherwise.
REQ-016 Latency: normal op, div_valid_o high in the cycle after N+1 edges counted from (and including) the accept edge; special case, cycle after accept edge +1.
REQ-017 Divisor zero: quotient = all ones (XLEN bits, or 32 bits sign-extended for W ops); remainder = dividend (W ops: low 32 bits sign-extended).
REQ-018 Signed overflow (most-negative / -1, at 64 or 32 bits): quotient = most-negative value; remainder = 0.
REQ-019 Signed ops: divide magnitudes; negate quotient when operand signs differ; remainder takes dividend sign; truncation toward zero.
REQ-020 W ops: use src[31:0] only (sign-extend for divw/remw, zero-extend for divuw/remuw); result bit 31 sign-extended to XLEN.
REQ-021 div_en_i SHALL be ignored in CALC and DONE; operand latches hold while not IDLE.
REQ-022 flush_i=1 in any state -> IDLE next edge; no div_valid_o for the aborted op; flush_i wins over simultaneous div_en_i.
REQ-023 div_result_o SHALL hold its last value outside DONE; consumers use it only when div_valid_o=1.

Reset
REQ-024 rst=1 at a rising edge -> state IDLE, counter 0, operand/quotient/remainder registers 0, div_result_o 0, div_valid_o 0; div_busy_o 0 while rst=1.
REQ-025 Reset mid-CALC or in DONE SHALL abort without emitting div_valid_o.

Verification
REQ-026 divu src1=100, src2=7: busy 1 from accept through CALC, div_valid_o after 65 edges from accept, result 14; remu same operands -> 2.
REQ-027 div src1=-7, src2=2 -> 0xFFFF_FFFF_FFFF_FFFD (-3); rem -> 0xFFFF_FFFF_FFFF_FFFF (-1).
REQ-028 divu 5/0 -> 0xFFFF_FFFF_FFFF_FFFF, remu 5/0 -> 5; div_valid_o one cycle after accept edge, no CALC state.
REQ-029 div 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000; rem -> 0; single-cycle special path.
REQ-030 divuw src1=0x0000_0000_FFFF_FFFF, src2=1 -> 0xFFFF_FFFF_FFFF_FFFF after 33 edges; divw src1=0x1234_5678_FFFF_FFF9, src2=2 -> 0xFFFF_FFFF_FFFF_FFFD.
REQ-031 flush_i pulsed 10 cycles into a divu -> IDLE next edge, busy 0, no div_valid_o; a new divu 9/3 issued next cycle -> result 3 with normal latency.

Source files
------------

// File: rtl/ex_div_unit_if.sv
// Request/response bundle between the EX stage and the iterative divider.
// The master drives the request; the slave answers with busy/valid/result.
interface ex_div_unit_if #(
    parameter int XLEN = 64
);
    logic            div_en_i;
    logic [2:0]      div_sel_i;
    logic [XLEN-1:0] src1_i;
    logic [XLEN-1:0] src2_i;
    logic            flush_i;
    logic            div_busy_o;
    logic            div_valid_o;
    logic [XLEN-1:0] div_result_o;

    modport master (
        output div_en_i, div_sel_i, src1_i, src2_i, flush_i,
        input  div_busy_o, div_valid_o, div_result_o
    );

    modport slave (
        input  div_en_i, div_sel_i, src1_i, src2_i, flush_i,
        output div_busy_o, div_valid_o, div_result_o
    );
endinterface

// File: rtl/ex_div_unit.sv
// RV64M iterative restoring divider: one quotient bit per cycle,
// divide-by-zero and signed overflow resolved at accept time.
module ex_div_unit #(
    parameter int XLEN = 64
) (
    input logic          clk,
    input logic          rst,
    ex_div_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_W = {{(XLEN-31){1'b1}}, {31{1'b0}}};

    state_t          state;
    logic [6:0]      cnt;
    logic [2:0]      sel_q;
    logic [XLEN-1:0] dvs;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] quo;
    logic            neg_q;
    logic            neg_r;
    logic            valid_q;
    logic [XLEN-1:0] result_q;

    function automatic logic [XLEN-1:0] sx32(input logic [XLEN-1:0] v);
        return {{(XLEN-32){v[31]}}, v[31:0]};
    endfunction

    // Operand conditioning at accept time
    logic            w_op;
    logic            sgn;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            s1;
    logic            s2;
    logic [XLEN-1:0] mag1;
    logic [XLEN-1:0] mag2;
    logic            dz;
    logic            ovf;
    logic [XLEN-1:0] spec_res;

    always_comb begin
        w_op = bus.div_sel_i[2];
        sgn  = ~bus.div_sel_i[0];
        op1  = bus.src1_i;
        op2  = bus.src2_i;
        if (w_op) begin
            op1 = sgn ? sx32(bus.src1_i) : {{(XLEN-32){1'b0}}, bus.src1_i[31:0]};
            op2 = sgn ? sx32(bus.src2_i) : {{(XLEN-32){1'b0}}, bus.src2_i[31:0]};
        end
        s1   = sgn & op1[XLEN-1];
        s2   = sgn & op2[XLEN-1];
        mag1 = s1 ? -op1 : op1;
        mag2 = s2 ? -op2 : op2;
        dz   = (op2 == '0);
        ovf  = sgn & (op2 == '1) & (op1 == (w_op ? MIN_W : MIN_X));
        if (bus.div_sel_i[1])
            spec_res = dz ? (w_op ? sx32(bus.src1_i) : bus.src1_i) : '0;
        else
            spec_res = dz ? '1 : op1;
    end

    // One restoring step and the result it would produce if it is the last
    logic [XLEN:0]   nxt;
    logic [XLEN:0]   diff;
    logic            ok;
    logic [XLEN-1:0] rem_n;
    logic [XLEN-1:0] quo_n;
    logic [XLEN-1:0] q_s;
    logic [XLEN-1:0] r_s;
    logic [XLEN-1:0] fin_res;

    always_comb begin
        nxt     = {rem, quo[XLEN-1]};
        diff    = nxt - {1'b0, dvs};
        ok      = ~diff[XLEN];
        rem_n   = ok ? diff[XLEN-1:0] : nxt[XLEN-1:0];
        quo_n   = {quo[XLEN-2:0], ok};
        q_s     = neg_q ? -quo_n : quo_n;
        r_s     = neg_r ? -rem_n : rem_n;
        fin_res = sel_q[1] ? r_s : q_s;
        if (sel_q[2])
            fin_res = sx32(fin_res);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            sel_q    <= '0;
            dvs      <= '0;
            rem      <= '0;
            quo      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else if (bus.flush_i) begin
            state   <= IDLE;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.div_en_i) begin
                        sel_q <= bus.div_sel_i;
                        dvs   <= mag2;
                        rem   <= '0;
                        // W dividends start at the top so 32 shifts consume them
                        quo   <= w_op ? {mag1[31:0], {(XLEN-32){1'b0}}} : mag1;
                        neg_q <= s1 ^ s2;
                        neg_r <= s1;
                        if (dz || ovf) begin
                            state    <= DONE;
                            cnt      <= '0;
                            valid_q  <= 1'b1;
                            result_q <= spec_res;
                        end else begin
                            state <= CALC;
                            cnt   <= w_op ? 7'd32 : 7'd64;
                        end
                    end
                end
                CALC: begin
                    rem <= rem_n;
                    quo <= quo_n;
                    cnt <= cnt - 7'd1;
                    if (cnt == 7'd1) begin
                        state    <= DONE;
                        valid_q  <= 1'b1;
                        result_q <= fin_res;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.div_busy_o   = ~rst & ((state == CALC) |
                              ((state == IDLE) & bus.div_en_i & ~bus.flush_i));
    assign bus.div_valid_o  = valid_q;
    assign bus.div_result_o = result_q;
endmodule

// File: tb/tb_ex_div_unit.sv
// Bench for ex_div_unit: directed vector table, random ops against an
// arithmetic reference, and flush/reset abort sequences.
module tb_ex_div_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    ex_div_unit_if #(.XLEN(64)) bus();
    ex_div_unit #(.XLEN(64)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        string       name;
        logic [2:0]  sel;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    localparam longint MINX = longint'(64'h8000_0000_0000_0000);
    localparam longint MINW = -longint'(32'h8000_0000);

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] sel, input logic [63:0] a,
                                          input logic [63:0] b);
        bit w = sel[2];
        bit sg = !sel[0];
        longint sa, sb;
        logic [63:0] ua, ub, q, r, res;
        logic [31:0] a32, b32;
        a32 = a[31:0];
        b32 = b[31:0];
        sa = w ? longint'($signed(a32)) : longint'(a);
        sb = w ? longint'($signed(b32)) : longint'(b);
        ua = w ? {32'b0, a32} : a;
        ub = w ? {32'b0, b32} : b;
        if (sg) begin
            if (sb == 0) begin
                q = '1;
                r = sa;
            end else if (sb == -1 && sa == (w ? MINW : MINX)) begin
                q = sa;
                r = 0;
            end else begin
                q = sa / sb;
                r = sa % sb;
            end
        end else begin
            if (ub == 0) begin
                q = '1;
                r = ua;
            end else begin
                q = ua / ub;
                r = ua % ub;
            end
        end
        res = sel[1] ? r : q;
        if (w) res = {{32{res[31]}}, res[31:0]};
        return res;
    endfunction

    function automatic int model_lat(input logic [2:0] sel, input logic [63:0] a,
                                     input logic [63:0] b);
        bit w = sel[2];
        bit sg = !sel[0];
        logic [31:0] a32, b32;
        bit zero, ovf;
        a32 = a[31:0];
        b32 = b[31:0];
        zero = w ? (b32 == 0) : (b == 0);
        ovf = sg && (w ? (b32 == '1 && a32 == 32'h8000_0000)
                       : (b == '1 && a == 64'h8000_0000_0000_0000));
        return (zero || ovf) ? 1 : (w ? 33 : 65);
    endfunction

    task automatic run_op(input string nm, input logic [2:0] sel, input logic [63:0] a,
                          input logic [63:0] b, output logic [63:0] res, output int lat);
        int gap = 0;
        @(negedge clk);
        bus.div_en_i  = 1'b1;
        bus.div_sel_i = sel;
        bus.src1_i    = a;
        bus.src2_i    = b;
        #1 check({nm, ".busy_req"}, 64'(bus.div_busy_o), 64'd1);
        @(posedge clk);
        lat = 1;
        #1 bus.div_en_i = 1'b0;
        while (!bus.div_valid_o && lat < 200) begin
            if (!bus.div_busy_o) gap++;
            @(posedge clk);
            lat++;
            #1;
        end
        res = bus.div_result_o;
        check({nm, ".busy_calc"}, 64'(gap), 64'd0);
        check({nm, ".busy_done"}, 64'(bus.div_busy_o), 64'd0);
        @(posedge clk);
        #1 check({nm, ".valid_1cyc"}, 64'(bus.div_valid_o), 64'd0);
    endtask

    vec_t vt[13];

    function automatic vec_t mk(input string n, input logic [2:0] s, input logic [63:0] a,
                                input logic [63:0] b, input logic [63:0] e, input int l);
        vec_t v;
        v.name = n; v.sel = s; v.a = a; v.b = b; v.exp = e; v.lat = l;
        return v;
    endfunction

    function automatic logic [63:0] pick();
        unique case ($urandom_range(0, 6))
            0: return 64'd0;
            1: return '1;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'hFFFF_FFFF_8000_0000;
            4: return 64'($urandom_range(0, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        logic [63:0] res;
        int lat;
        int seen;

        vt[0]  = mk("divu_100_7",  3'b001, 64'd100, 64'd7, 64'd14, 65);
        vt[1]  = mk("remu_100_7",  3'b011, 64'd100, 64'd7, 64'd2, 65);
        vt[2]  = mk("div_m7_2",    3'b000, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
                    64'hFFFF_FFFF_FFFF_FFFD, 65);
        vt[3]  = mk("rem_m7_2",    3'b010, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '1, 65);
        vt[4]  = mk("divu_5_0",    3'b001, 64'd5, 64'd0, '1, 1);
        vt[5]  = mk("remu_5_0",    3'b011, 64'd5, 64'd0, 64'd5, 1);
        vt[6]  = mk("div_ovf",     3'b000, 64'h8000_0000_0000_0000, '1,
                    64'h8000_0000_0000_0000, 1);
        vt[7]  = mk("rem_ovf",     3'b010, 64'h8000_0000_0000_0000, '1, 64'd0, 1);
        vt[8]  = mk("divuw_ff_1",  3'b101, 64'h0000_0000_FFFF_FFFF, 64'd1, '1, 33);
        vt[9]  = mk("divw_m7_2",   3'b100, 64'h1234_5678_FFFF_FFF9, 64'd2,
                    64'hFFFF_FFFF_FFFF_FFFD, 33);
        vt[10] = mk("divw_ovf",    3'b100, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
                    64'hFFFF_FFFF_8000_0000, 1);
        vt[11] = mk("remuw_z",     3'b111, 64'hDEAD_BEEF_8000_0001, 64'hFFFF_FFFF_0000_0000,
                    64'hFFFF_FFFF_8000_0001, 1);
        vt[12] = mk("rem_7_m2",    3'b010, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 65);

        bus.div_en_i  = 1'b1;
        bus.div_sel_i = 3'b001;
        bus.src1_i    = 64'd9;
        bus.src2_i    = 64'd3;
        bus.flush_i   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.busy", 64'(bus.div_busy_o), 64'd0);
        check("rst.valid", 64'(bus.div_valid_o), 64'd0);
        check("rst.result", bus.div_result_o, 64'd0);
        @(negedge clk);
        bus.div_en_i = 1'b0;
        rst = 1'b0;
        #1 check("idle.busy", 64'(bus.div_busy_o), 64'd0);

        foreach (vt[i]) begin
            run_op(vt[i].name, vt[i].sel, vt[i].a, vt[i].b, res, lat);
            check({vt[i].name, ".result"}, res, vt[i].exp);
            check({vt[i].name, ".latency"}, 64'(lat), 64'(vt[i].lat));
        end

        repeat (3) @(posedge clk);
        #1 check("result_hold", bus.div_result_o, vt[12].exp);

        for (int i = 0; i < 40; i++) begin
            logic [2:0] s;
            logic [63:0] a, b;
            s = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            run_op("rand", s, a, b, res, lat);
            check("rand.result", res, model(s, a, b));
            check("rand.latency", 64'(lat), 64'(model_lat(s, a, b)));
        end

        // flush 10 cycles into a long divide
        @(negedge clk);
        bus.div_en_i = 1'b1; bus.div_sel_i = 3'b001;
        bus.src1_i = 64'd1000; bus.src2_i = 64'd3;
        @(posedge clk);
        #1 bus.div_en_i = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.flush_i = 1'b1;
        @(posedge clk);
        #1;
        check("flush.busy", 64'(bus.div_busy_o), 64'd0);
        check("flush.valid", 64'(bus.div_valid_o), 64'd0);
        @(negedge clk);
        bus.flush_i = 1'b0;
        run_op("after_flush", 3'b001, 64'd9, 64'd3, res, lat);
        check("after_flush.result", res, 64'd3);
        check("after_flush.latency", 64'(lat), 64'd65);

        // flush wins over a simultaneous request
        @(negedge clk);
        bus.div_en_i = 1'b1; bus.flush_i = 1'b1;
        bus.div_sel_i = 3'b001; bus.src1_i = 64'd8; bus.src2_i = 64'd0;
        #1 check("flush_en.busy", 64'(bus.div_busy_o), 64'd0);
        @(posedge clk);
        #1 bus.div_en_i = 1'b0;
        bus.flush_i = 1'b0;
        seen = 0;
        repeat (5) begin
            @(posedge clk);
            #1 if (bus.div_valid_o || bus.div_busy_o) seen++;
        end
        check("flush_en.quiet", 64'(seen), 64'd0);

        // reset in the middle of CALC
        @(negedge clk);
        bus.div_en_i = 1'b1; bus.div_sel_i = 3'b001;
        bus.src1_i = 64'd50; bus.src2_i = 64'd3;
        @(posedge clk);
        #1 bus.div_en_i = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_calc.busy", 64'(bus.div_busy_o), 64'd0);
        check("rst_calc.result", bus.div_result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (70) begin
            @(posedge clk);
            #1 if (bus.div_valid_o || bus.div_busy_o) seen++;
        end
        check("rst_calc.quiet", 64'(seen), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
